// File: rtl/etm_error_accum.sv
// etm_error_accum: accumulates ETM multiplier error metrics over a run of NSAMP product pairs
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst_n        synchronous reset, active-low
//   start        pulse: clear results and begin a run (honoured in IDLE/DONE only)
//   in_valid     product pair valid
//   in_ready     block accepts a pair this cycle (state/counter only, never in_valid)
//   prod_approx  approximate product
//   prod_exact   exact reference product
//   busy         high in RUN or DRAIN
//   done         high in DONE; results final and stable
//   sum_abs_err  saturating sum of |approx-exact|
//   max_abs_err  largest |approx-exact| of the run
//   max_idx      0-based index of the first sample reaching max_abs_err
//   err_count    number of samples with approx != exact
module etm_error_accum #(
    parameter int W     = 32,
    parameter int ACC_W = 48,
    parameter int CNT_W = 16,
    parameter int NSAMP = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     prod_approx,
    input  logic [W-1:0]     prod_exact,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [W-1:0]     max_abs_err,
    output logic [CNT_W-1:0] max_idx,
    output logic [CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              s1_v_q;
    logic [W-1:0]      d_q;
    logic [CNT_W-1:0]  idx_q;
    logic [ACC_W-1:0]  sum_q;
    logic [W-1:0]      max_q;
    logic [CNT_W-1:0]  max_idx_q;
    logic [CNT_W-1:0]  err_q;
    logic              go;
    logic              hs;
    logic              last;
    logic [W:0]        diff;
    logic [W-1:0]      diff_lo;
    logic [W-1:0]      abs_d;
    logic [ACC_W:0]    sum_ext;
    logic [ACC_W-1:0]  sum_sat;
    assign go      = start && (state_q == IDLE || state_q == DONE);
    assign hs      = in_valid && in_ready;
    assign last    = hs && (cnt_q == CNT_W'(NSAMP - 1));
    // W+1-bit signed difference; magnitude never exceeds 2^W-1 so the low W bits suffice
    assign diff    = {1'b0, prod_approx} - {1'b0, prod_exact};
    assign diff_lo = diff[W-1:0];
    assign abs_d   = diff[W] ? -diff_lo : diff_lo;
    // one extra bit catches the carry out; once saturated, adding d>=0 keeps it saturated
    assign sum_ext = {1'b0, sum_q} + (ACC_W + 1)'(d_q);
    assign sum_sat = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last ? DRAIN : RUN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = start ? RUN : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        in_ready = (state_q == RUN) && (cnt_q < CNT_W'(NSAMP));
        busy     = (state_q == RUN) || (state_q == DRAIN);
        done     = (state_q == DONE);
    end
    always_ff @(posedge clk) begin
        if (!rst_n || go) begin
            cnt_q     <= '0;
            s1_v_q    <= 1'b0;
            d_q       <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
            err_q     <= '0;
        end else begin
            s1_v_q <= hs;
            if (hs) begin
                d_q   <= abs_d;
                idx_q <= cnt_q;
                cnt_q <= cnt_q + 1'b1;
            end
            if (s1_v_q) begin
                sum_q <= sum_sat;
                err_q <= err_q + CNT_W'(d_q != '0);
                if (d_q > max_q) begin
                    max_q     <= d_q;
                    max_idx_q <= idx_q;
                end
            end
        end
    end
    assign sum_abs_err = sum_q;
    assign max_abs_err = max_q;
    assign max_idx     = max_idx_q;
    assign err_count   = err_q;
endmodule

// File: tb/tb_etm_error_accum.sv
// tb_etm_error_accum: randomized scoreboard bench for etm_error_accum (NSAMP=4, ACC_W=33)
module tb_etm_error_accum;
    localparam int N = 4;
    localparam longint unsigned LIM = (64'd1 << 33) - 1;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic        in_valid = 1;
    logic        in_ready;
    logic [31:0] pa = 0;
    logic [31:0] pe = 0;
    logic        busy;
    logic        done;
    logic [32:0] sum_abs_err;
    logic [31:0] max_abs_err;
    logic [15:0] max_idx;
    logic [15:0] err_count;

    typedef struct {
        longint unsigned sum;
        longint unsigned mx;
        longint unsigned idx;
        longint unsigned cnt;
    } res_t;

    res_t        sb[$];
    bit   [31:0] qa[N];
    bit   [31:0] qe[N];
    int          total = 0;
    int          bad = 0;

    etm_error_accum #(.W(32), .ACC_W(33), .CNT_W(16), .NSAMP(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .prod_approx(pa), .prod_exact(pe), .busy(busy), .done(done),
        .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err), .max_idx(max_idx),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // reference: plain arithmetic over the run's pairs
    function automatic res_t model();
        res_t r;
        longint unsigned d;
        r.sum = 0; r.mx = 0; r.idx = 0; r.cnt = 0;
        for (int i = 0; i < N; i++) begin
            d = (qa[i] > qe[i]) ? longint'(qa[i]) - longint'(qe[i]) : longint'(qe[i]) - longint'(qa[i]);
            r.sum = (r.sum + d > LIM) ? LIM : r.sum + d;
            if (d > r.mx) begin
                r.mx  = d;
                r.idx = i;
            end
            if (d != 0) r.cnt++;
        end
        return r;
    endfunction

    task automatic gen();
        for (int i = 0; i < N; i++) begin
            int m;
            m = $urandom_range(0, 3);
            qe[i] = $urandom;
            if (m == 0) qa[i] = qe[i];
            else if (m == 1) qa[i] = qe[i] + 32'($urandom_range(0, 20)) - 32'd10;
            else if (m == 2) qa[i] = $urandom;
            else begin
                qa[i] = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0;
                qe[i] = $urandom_range(0, 1) ? 32'h0 : 32'hFFFF_FFFF;
            end
        end
    endtask

    task automatic set(input bit [31:0] a0, e0, a1, e1, a2, e2, a3, e3);
        qa[0] = a0; qe[0] = e0; qa[1] = a1; qe[1] = e1;
        qa[2] = a2; qe[2] = e2; qa[3] = a3; qe[3] = e3;
    endtask

    // gm: 0 back-to-back, 1 every other cycle, 2 random gaps
    task automatic run(input int gm, input bit extra, input bit mid);
        int n;
        sb.push_back(model());
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        for (int i = 0; i < N; i++) begin
            in_valid = 1; pa = qa[i]; pe = qe[i];
            if (mid && i == 2) start = 1;
            @(negedge clk);
            if (i == 0) begin
                chk("clr_sum", sum_abs_err, 0);
                chk("clr_max", max_abs_err, 0);
                chk("clr_idx", max_idx, 0);
                chk("clr_cnt", err_count, 0);
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
            end
            chk("ready", in_ready, 1);
            @(posedge clk); #1 start = 0; in_valid = 0;
            if (i < N - 1) begin
                n = (gm == 0) ? 0 : (gm == 1) ? 1 : $urandom_range(0, 2);
                repeat (n) begin @(posedge clk); #1; end
            end
        end
        in_valid = extra; pa = 32'hFFFF_FFFF; pe = 0;
        @(negedge clk);
        chk("drain_busy", busy, 1);
        chk("drain_done", done, 0);
        chk("drain_ready", in_ready, 0);
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk);
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sum"}, sum_abs_err, 0);
        chk({tag, "_max"}, max_abs_err, 0);
        chk({tag, "_idx"}, max_idx, 0);
        chk({tag, "_cnt"}, err_count, 0);
    endtask

    // monitor: compares one expected result set per rising edge of done
    initial begin
        res_t e;
        logic dp;
        dp = 0;
        forever begin
            @(negedge clk);
            if (done && !dp) begin
                if (sb.size() == 0) chk("done_unexpected", done, 0);
                else begin
                    e = sb.pop_front();
                    chk("sum_abs_err", sum_abs_err, e.sum);
                    chk("max_abs_err", max_abs_err, e.mx);
                    chk("max_idx", max_idx, e.idx);
                    chk("err_count", err_count, e.cnt);
                end
            end
            dp = done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        chk_zero("rst");
        @(posedge clk); #1 rst_n = 1; in_valid = 0;
        set(100, 100, 200, 195, 7, 12, 0, 0);
        run(0, 0, 0);
        run(1, 1, 0);
        set(32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0);
        run(0, 0, 0);
        set(15, 10, 1, 10, 29, 20, 3, 0);
        run(2, 1, 0);
        set(42, 42, 7, 7, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(0, 0, 0);
        gen();
        run(2, 0, 1);
        gen();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; pa = qa[i]; pe = qe[i];
            @(posedge clk); #1;
        end
        in_valid = 0; rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        chk_zero("abort");
        for (int k = 0; k < 12; k++) begin
            gen();
            run(2, k[0], k[1]);
        end
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
